// File: rtl/t_word_store_pkg.sv
// -----------------------------------------------------------------------------
// t_word_store_pkg
// Shared constants and FSM encoding for the T word store.
//   Sram_Word      : SRAM word width in bits
//   Max_T_size_log : width of the T-length field
//   Depth_Log      : log2 of the store capacity in words
//   state_e        : store FSM states (IDLE -> LOAD -> RUN)
// -----------------------------------------------------------------------------
package t_word_store_pkg;

    localparam int Sram_Word      = 64;
    localparam int Max_T_size_log = 16;
    localparam int Depth_Log      = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage : t_word_store_pkg

// File: rtl/t_word_store_if.sv
// -----------------------------------------------------------------------------
// t_word_store_if
// Word traffic between the store and its users.
//   SRAM side : i_sram_request / o_request_data (pop), i_sram_send /
//               i_send_data (push back of spilled words)
//   Load side : i_load_valid / i_load_data / i_load_last / i_load_t_size,
//               o_load_ready (valid/ready handshake)
// Modports:
//   master : the DataProcessor and top-level loader
//   slave  : the word store
// -----------------------------------------------------------------------------
interface t_word_store_if
    import t_word_store_pkg::*;
#(
    parameter int SRAM_WORD      = Sram_Word,
    parameter int MAX_T_SIZE_LOG = Max_T_size_log
);

    logic                      i_sram_request;
    logic [SRAM_WORD-1:0]      o_request_data;
    logic                      i_sram_send;
    logic [SRAM_WORD-1:0]      i_send_data;
    logic                      i_load_valid;
    logic [SRAM_WORD-1:0]      i_load_data;
    logic                      i_load_last;
    logic [MAX_T_SIZE_LOG-1:0] i_load_t_size;
    logic                      o_load_ready;

    modport master (
        output i_sram_request, i_sram_send, i_send_data,
               i_load_valid, i_load_data, i_load_last, i_load_t_size,
        input  o_request_data, o_load_ready
    );

    modport slave (
        input  i_sram_request, i_sram_send, i_send_data,
               i_load_valid, i_load_data, i_load_last, i_load_t_size,
        output o_request_data, o_load_ready
    );

endinterface : t_word_store_if

// File: rtl/t_word_store_mem.sv
// -----------------------------------------------------------------------------
// t_word_store_mem
// 1R1W synchronous RAM, 2^ADDR_W x WIDTH, read-first, registered read data.
//   clk, rst_n : clock, synchronous active-low reset (read register only)
//   wr_en, wr_addr, wr_data : write port
//   rd_en, rd_addr          : read port; rd_data updates only when rd_en
//   rd_data                 : registered read data, held between reads
// -----------------------------------------------------------------------------
module t_word_store_mem #(
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // NOTE: the array has no reset so it maps onto RAM macros; its contents
    // are never observable before being written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // NOTE: non-blocking assignments give read-first behaviour: a read of the
    // address being written in the same cycle returns the old word, which is
    // what a full store doing pop+push on the same slot needs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : t_word_store_mem

// File: rtl/t_word_store.sv
// -----------------------------------------------------------------------------
// t_word_store
// Ring-buffer word store answering the DataProcessor SRAM handshake. The
// packed target sequence T is loaded first (IDLE/LOAD); in RUN each request
// pops one word in FIFO order and each send pushes a spilled word back.
//   clk, rst_n    : clock, synchronous active-low reset
//   bus (slave)   : SRAM request/send and load handshake (t_word_store_if)
//   i_clear       : return to IDLE and empty the store (highest priority)
//   o_T_size      : T length latched with the first load word
//   o_busy        : high while in RUN
//   o_count       : occupancy, 0 .. 2^DEPTH_LOG
//   o_overflow    : sticky, send while full without a request
//   o_underflow   : sticky, request while empty (and not forwarded)
// Optional feature: define T_WORD_STORE_BYPASS_EN to forward i_send_data
// straight to o_request_data when request and send coincide on an empty store.
// -----------------------------------------------------------------------------
module t_word_store
    import t_word_store_pkg::*;
#(
    parameter int SRAM_WORD      = Sram_Word,
    parameter int DEPTH_LOG      = Depth_Log,
    parameter int MAX_T_SIZE_LOG = Max_T_size_log
) (
    input  logic                      clk,
    input  logic                      rst_n,
    t_word_store_if.slave             bus,
    input  logic                      i_clear,
    output logic [MAX_T_SIZE_LOG-1:0] o_T_size,
    output logic                      o_busy,
    output logic [DEPTH_LOG:0]        o_count,
    output logic                      o_overflow,
    output logic                      o_underflow
);

    localparam int unsigned          Capacity   = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0]   Full_Count = Capacity[DEPTH_LOG:0];

    state_e                 state_q, state_d;
    logic [DEPTH_LOG-1:0]   rd_ptr_q, wr_ptr_q;
    logic [DEPTH_LOG:0]     count_q;
    logic [SRAM_WORD-1:0]   mem_rd_data;
    logic [SRAM_WORD-1:0]   wr_data;

    logic is_run, is_empty, is_full;
    logic load_acc, req, snd, bypass_hit, push, pop, set_udf, set_ovf;

    assign is_run   = (state_q == ST_RUN);
    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == Full_Count);

    // Accepted events; clear suppresses every one of them in its cycle.
    assign load_acc = bus.i_load_valid && bus.o_load_ready && !i_clear;
    assign req      = is_run && bus.i_sram_request && !i_clear;
    assign snd      = is_run && bus.i_sram_send && !i_clear;

`ifdef T_WORD_STORE_BYPASS_EN
    assign bypass_hit = req && snd && is_empty;
`else
    assign bypass_hit = 1'b0;
`endif

    // A send at full is only taken when a request frees the slot this cycle.
    assign pop     = req && !is_empty;
    assign push    = load_acc || (snd && !bypass_hit && (!is_full || req));
    assign set_udf = req && is_empty && !bypass_hit;
    assign set_ovf = snd && is_full && !req;
    assign wr_data = is_run ? bus.i_send_data : bus.i_load_data;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: state_d gets a default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (i_clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: if (load_acc) state_d = bus.i_load_last ? ST_RUN : ST_LOAD;
                ST_LOAD: if (load_acc && bus.i_load_last) state_d = ST_RUN;
                ST_RUN:  state_d = ST_RUN;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy           = (state_q == ST_RUN);
        bus.o_load_ready = (state_q != ST_RUN) && !is_full;
    end

    // ---------------- Pointers, count, T length, flags ----------------
    always_ff @(posedge clk) begin
        if (!rst_n || i_clear) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            o_T_size    <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + (DEPTH_LOG+1)'(1);
                2'b01:   count_q <= count_q - (DEPTH_LOG+1)'(1);
                default: count_q <= count_q;
            endcase
            if (load_acc && state_q == ST_IDLE) o_T_size <= bus.i_load_t_size;
            if (set_ovf) o_overflow  <= 1'b1;
            if (set_udf) o_underflow <= 1'b1;
        end
    end

    assign o_count = count_q;

    t_word_store_mem #(
        .WIDTH  (SRAM_WORD),
        .ADDR_W (DEPTH_LOG)
    ) u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_addr (rd_ptr_q),
        .rd_data (mem_rd_data)
    );

`ifdef T_WORD_STORE_BYPASS_EN
    // Forwarded word overrides the RAM output until the next real pop.
    logic                 fwd_sel_q;
    logic [SRAM_WORD-1:0] fwd_data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_sel_q  <= 1'b0;
            fwd_data_q <= '0;
        end else if (bypass_hit) begin
            fwd_sel_q  <= 1'b1;
            fwd_data_q <= bus.i_send_data;
        end else if (pop) begin
            fwd_sel_q  <= 1'b0;
        end
    end

    assign bus.o_request_data = fwd_sel_q ? fwd_data_q : mem_rd_data;
`else
    assign bus.o_request_data = mem_rd_data;
`endif

endmodule : t_word_store

// File: tb/tb_t_word_store.sv
// -----------------------------------------------------------------------------
// tb_t_word_store
// Directed bench for t_word_store: load, FIFO pops, steady pop+push across the
// pointer wrap, full/overflow, empty/underflow (bypass-aware), clear mid-LOAD
// and reset mid-RUN. Expected values are hand-derived constants plus a
// reference queue of the words the store should hold.
// -----------------------------------------------------------------------------
module tb_t_word_store;

    localparam int W  = 64;
    localparam int DL = 6;
    localparam int TL = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_clear;
    logic [TL-1:0] o_T_size;
    logic          o_busy;
    logic [DL:0]   o_count;
    logic          o_overflow;
    logic          o_underflow;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] model_q [$];
    logic [W-1:0] exp_word;

    t_word_store_if #(.SRAM_WORD(W), .MAX_T_SIZE_LOG(TL)) bus ();

    t_word_store #(
        .SRAM_WORD      (W),
        .DEPTH_LOG      (DL),
        .MAX_T_SIZE_LOG (TL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .i_clear     (i_clear),
        .o_T_size    (o_T_size),
        .o_busy      (o_busy),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_sram_request = 1'b0;
        bus.i_sram_send    = 1'b0;
        bus.i_send_data    = '0;
        bus.i_load_valid   = 1'b0;
        bus.i_load_data    = '0;
        bus.i_load_last    = 1'b0;
        bus.i_load_t_size  = '0;
        i_clear            = 1'b0;
    endtask

    task automatic load_word(input logic [W-1:0] d, input logic [TL-1:0] ts, input logic last);
        bus.i_load_valid  = 1'b1;
        bus.i_load_data   = d;
        bus.i_load_t_size = ts;
        bus.i_load_last   = last;
        tick();
        bus.i_load_valid  = 1'b0;
        bus.i_load_last   = 1'b0;
    endtask

    task automatic send_only(input logic [W-1:0] d);
        bus.i_sram_send = 1'b1;
        bus.i_send_data = d;
        tick();
        bus.i_sram_send = 1'b0;
    endtask

    task automatic request_only();
        bus.i_sram_request = 1'b1;
        tick();
        bus.i_sram_request = 1'b0;
    endtask

    task automatic req_and_send(input logic [W-1:0] d);
        bus.i_sram_request = 1'b1;
        bus.i_sram_send    = 1'b1;
        bus.i_send_data    = d;
        tick();
        bus.i_sram_request = 1'b0;
        bus.i_sram_send    = 1'b0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_count"},  W'(o_count),            W'(0));
        check({pfx, "_busy"},   W'(o_busy),             W'(0));
        check({pfx, "_tsize"},  W'(o_T_size),           W'(0));
        check({pfx, "_rdata"},  bus.o_request_data,     W'(0));
        check({pfx, "_ovf"},    W'(o_overflow),         W'(0));
        check({pfx, "_udf"},    W'(o_underflow),        W'(0));
        check({pfx, "_ready"},  W'(bus.o_load_ready),   W'(1));
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;

        // ---- Load A1, A2, A3; t_size only taken with the first word ----
        load_word(64'hA1, 16'd40, 1'b0);
        check("load1_busy", W'(o_busy), W'(0));
        load_word(64'hA2, 16'd99, 1'b0);
        load_word(64'hA3, 16'd77, 1'b1);
        check("load_tsize", W'(o_T_size), W'(40));
        check("load_busy",  W'(o_busy),   W'(1));
        check("load_count", W'(o_count),  W'(3));
        check("run_ready",  W'(bus.o_load_ready), W'(0));

        // ---- Three back-to-back pops ----
        bus.i_sram_request = 1'b1;
        tick(); check("pop_a1", bus.o_request_data, 64'hA1);
        tick(); check("pop_a2", bus.o_request_data, 64'hA2);
        tick(); check("pop_a3", bus.o_request_data, 64'hA3);
        bus.i_sram_request = 1'b0;
        check("pop_count0", W'(o_count), W'(0));

        // ---- Refill to 3, then 100 cycles of pop+push across the wrap ----
        for (int i = 1; i <= 3; i++) begin
            send_only(64'hD0 + W'(i));
            model_q.push_back(64'hD0 + W'(i));
        end
        check("refill_count", W'(o_count), W'(3));
        for (int i = 0; i < 100; i++) begin
            req_and_send(64'hB000 + W'(i));
            exp_word = model_q.pop_front();
            model_q.push_back(64'hB000 + W'(i));
            check($sformatf("steady_%0d", i), bus.o_request_data, exp_word);
        end
        check("steady_count", W'(o_count),     W'(3));
        check("steady_ovf",   W'(o_overflow),  W'(0));
        check("steady_udf",   W'(o_underflow), W'(0));

        // ---- Fill to capacity ----
        for (int i = 0; i < 61; i++) begin
            send_only(64'hF000 + W'(i));
            model_q.push_back(64'hF000 + W'(i));
        end
        check("full_count", W'(o_count), W'(64));

        req_and_send(64'hE0);
        exp_word = model_q.pop_front();
        model_q.push_back(64'hE0);
        check("full_rs_data",  bus.o_request_data, exp_word);
        check("full_rs_count", W'(o_count),        W'(64));
        check("full_rs_ovf",   W'(o_overflow),     W'(0));

        send_only(64'hDEAD);
        check("ovf_flag",  W'(o_overflow), W'(1));
        check("ovf_count", W'(o_count),    W'(64));

        // Drain: DEAD must not appear, E0 comes out last.
        for (int i = 0; i < 64; i++) begin
            request_only();
            exp_word = model_q.pop_front();
            check($sformatf("drain_%0d", i), bus.o_request_data, exp_word);
        end
        check("drain_count", W'(o_count), W'(0));

        // ---- Underflow on empty: data holds ----
        request_only();
        check("udf_flag",  W'(o_underflow),     W'(1));
        check("udf_hold",  bus.o_request_data,  64'hE0);
        check("udf_count", W'(o_count),         W'(0));

        // ---- Clear from RUN ----
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        check("clr_busy",  W'(o_busy),           W'(0));
        check("clr_count", W'(o_count),          W'(0));
        check("clr_ovf",   W'(o_overflow),       W'(0));
        check("clr_udf",   W'(o_underflow),      W'(0));
        check("clr_ready", W'(bus.o_load_ready), W'(1));

        // Request/send outside RUN are ignored.
        req_and_send(64'h55);
        check("idle_rs_count", W'(o_count),     W'(0));
        check("idle_rs_udf",   W'(o_underflow), W'(0));
        check("idle_rs_busy",  W'(o_busy),      W'(0));

        // ---- Single-word load, pop, then request+send on empty ----
        load_word(64'hF1, 16'd7, 1'b1);
        check("f1_tsize", W'(o_T_size), W'(7));
        check("f1_count", W'(o_count),  W'(1));
        request_only();
        check("f1_pop", bus.o_request_data, 64'hF1);

        req_and_send(64'hC5);
`ifdef T_WORD_STORE_BYPASS_EN
        check("byp_data",  bus.o_request_data, 64'hC5);
        check("byp_count", W'(o_count),        W'(0));
        check("byp_udf",   W'(o_underflow),    W'(0));
`else
        check("nobyp_udf",   W'(o_underflow),    W'(1));
        check("nobyp_count", W'(o_count),        W'(1));
        check("nobyp_hold",  bus.o_request_data, 64'hF1);
        request_only();
        check("nobyp_pop",   bus.o_request_data, 64'hC5);
        check("nobyp_count0", W'(o_count),       W'(0));
`endif

        // ---- Clear mid-LOAD together with a valid load word ----
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        load_word(64'h61, 16'd5, 1'b0);
        check("g1_count", W'(o_count),  W'(1));
        check("g1_tsize", W'(o_T_size), W'(5));
        i_clear = 1'b1;
        load_word(64'h62, 16'd6, 1'b0);
        i_clear = 1'b0;
        check("lclr_count", W'(o_count),          W'(0));
        check("lclr_tsize", W'(o_T_size),         W'(0));
        check("lclr_busy",  W'(o_busy),           W'(0));
        check("lclr_ready", W'(bus.o_load_ready), W'(1));
        load_word(64'h71, 16'd9, 1'b1);
        check("h1_count", W'(o_count),  W'(1));
        check("h1_tsize", W'(o_T_size), W'(9));
        request_only();
        check("h1_pop", bus.o_request_data, 64'h71);

        // ---- Reset mid-RUN with count 10 and a flag set ----
        request_only();
        check("pre_rst_udf", W'(o_underflow), W'(1));
        for (int i = 0; i < 10; i++) send_only(64'h300 + W'(i));
        check("pre_rst_count", W'(o_count), W'(10));
        rst_n = 1'b0;
        tick();
        check_reset_outputs("mrst");
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_t_word_store
